// File: rtl/dom_stim_sequencer_pkg.sv
// Shared definitions for the DOM stimulus/capture sequencer: state and
// randomness-source encodings, LFSR constants and the fresh-randomness width.
package dom_stim_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_t;

    // Code 3 is reserved and behaves exactly like the LFSR source.
    typedef enum logic [1:0] {
        RM_LFSR  = 2'd0,
        RM_ZERO  = 2'd1,
        RM_REUSE = 2'd2,
        RM_RSVD  = 2'd3
    } rand_mode_t;

    localparam logic [31:0] LFSR_TAPS        = 32'h8020_0003;
    localparam logic [31:0] LFSR_LOCKUP_SEED = 32'hFFFF_FFFF;

    // One fresh random bit per unordered share pair of the DOM multiplier.
    function automatic int rand_width(input int shares);
        return shares * (shares - 1) / 2;
    endfunction

endpackage

// File: rtl/dom_stim_sequencer_lfsr.sv
// 32-bit right-shifting Galois LFSR; a zero seed is replaced by all-ones so
// the register can never lock up. Only the low OUT_W bits are exported.
module lfsr_galois32
    import dom_stim_sequencer_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [31:0]      seed,
    input  logic             step,
    output logic [OUT_W-1:0] state
);

    logic [31:0] lfsr_q;

    // A load in the same cycle as a step wins, so a new seed is never stepped.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_LOCKUP_SEED;
        end else if (load) begin
            lfsr_q <= (seed == 32'h0) ? LFSR_LOCKUP_SEED : seed;
        end else if (step) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    assign state = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/dom_stim_sequencer.sv
// Stimulus/capture sequencer for a masked DOM gadget: launches each input lane
// at its own programmable offset, then captures and checks the output shares.
module dom_stim_sequencer
    import dom_stim_sequencer_pkg::*;
#(
    parameter int SHARES = 4,
    parameter int RAND_W = rand_width(SHARES),
    parameter int IN_W   = 2 * SHARES + RAND_W,
    parameter int SKEW_W = 3,
    parameter int LAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(IN_W)-1:0]   cfg_lane,
    input  logic [SKEW_W-1:0]         cfg_skew,
    input  logic                      seed_we,
    input  logic [31:0]               seed,
    input  logic [1:0]                rand_mode,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SHARES-1:0]         s_a,
    input  logic [SHARES-1:0]         s_b,
    output logic [IN_W-1:0]           dut_in,
    input  logic [SHARES-1:0]         dut_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [SHARES-1:0]         m_data,
    output logic                      m_unmasked,
    output logic                      m_err,
    output logic                      busy
);

    localparam int                 CNT_W     = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(LAT - 1);
    localparam logic [SKEW_W-1:0]  STEP_LAST = '1;

    seq_state_t          state, state_nx;
    logic [SKEW_W-1:0]   skew [IN_W];
    logic [SKEW_W-1:0]   step_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IN_W-1:0]     lat_vec;
    logic [RAND_W-1:0]   prev_rand;
    logic [RAND_W-1:0]   rand_sel;
    logic [RAND_W-1:0]   lfsr_bits;
    logic                accept;
    logic                idle;
    logic                lfsr_src;

    assign idle       = (state == ST_IDLE);
    assign s_ready    = idle && !rst;
    assign accept     = s_valid && s_ready;
    assign busy       = !idle;
    assign m_unmasked = ^m_data;
    assign lfsr_src   = (rand_mode != RM_ZERO) && (rand_mode != RM_REUSE);

    always_comb begin
        rand_sel = lfsr_bits;
        case (rand_mode)
            RM_ZERO:  rand_sel = '0;
            RM_REUSE: rand_sel = prev_rand;
            default:  rand_sel = lfsr_bits;
        endcase
    end

    lfsr_galois32 #(
        .OUT_W(RAND_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (seed_we && idle),
        .seed  (seed),
        .step  (accept && lfsr_src),
        .state (lfsr_bits)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept)              state_nx = ST_LAUNCH;
            ST_LAUNCH: if (step_q == STEP_LAST) state_nx = ST_WAIT;
            ST_WAIT:   if (cnt_q == CNT_LAST)   state_nx = ST_HOLD;
            ST_HOLD:   if (m_ready)             state_nx = ST_IDLE;
            default:                            state_nx = ST_IDLE;
        endcase
    end

    // Lanes not yet launched keep the previous transaction's bit on purpose.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in    <= '0;
            for (int i = 0; i < IN_W; i++) skew[i] <= '0;
            prev_rand <= '0;
            lat_vec   <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_err     <= 1'b0;
        end else begin
            if (idle && cfg_we && (32'(cfg_lane) < IN_W)) begin
                skew[cfg_lane] <= cfg_skew;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_vec   <= {s_a, s_b, rand_sel};
                        prev_rand <= rand_sel;
                        step_q    <= '0;
                    end
                end
                ST_LAUNCH: begin
                    for (int i = 0; i < IN_W; i++) begin
                        if (skew[i] == step_q) dut_in[i] <= lat_vec[i];
                    end
                    step_q <= step_q + SKEW_W'(1);
                    cnt_q  <= '0;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        m_data  <= dut_out;
                        m_valid <= 1'b1;
                        m_err   <= (^dut_out) !=
                                   ((^lat_vec[IN_W-1 -: SHARES]) & (^lat_vec[IN_W-SHARES-1 -: SHARES]));
                    end
                end
                ST_HOLD: begin
                    if (m_ready) m_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
